// File: rtl/thermal_frame_buffer_if.sv
// rtl/thermal_frame_buffer_if.sv - camera write stream and display read port bundle
interface thermal_frame_buffer_if #(
  parameter int WIDTH = 16
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic             sync_i;
  logic             frame_done_o;
  logic             rd_ready_i;
  logic [WIDTH-1:0] data_o;

  // Master side drives camera pixels and the display consume strobe.
  modport master (
    output valid_i, data_i, sync_i, rd_ready_i,
    input  ready_o, frame_done_o, data_o
  );

  // Slave side is the frame buffer itself.
  modport slave (
    input  valid_i, data_i, sync_i, rd_ready_i,
    output ready_o, frame_done_o, data_o
  );
endinterface

// File: rtl/thermal_frame_buffer.sv
// rtl/thermal_frame_buffer.sv - single frame store, raster write, pixel-replicated raster read
module thermal_frame_buffer #(
  parameter int WIDTH     = 16,
  parameter int SRC_W     = 80,
  parameter int SRC_H     = 60,
  parameter int SCALE     = 8,
  parameter int DISP_ROWS = 400
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  thermal_frame_buffer_if.slave  bus
);
  localparam int DEPTH  = SRC_W * SRC_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int COLS   = SRC_W * SCALE;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(DISP_ROWS);
  localparam int SHIFT  = $clog2(SCALE);

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              ready_q, ready_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [WIDTH-1:0]  data_q, data_d;

  logic              accept;
  logic [ADDR_W-1:0] wr_ptr;
  logic [COL_W-1:0]  col_nxt;
  logic [ROW_W-1:0]  row_nxt;
  logic [ROW_W-1:0]  src_row;
  logic [COL_W-1:0]  src_col;
  logic              blank;
  logic [ADDR_W-1:0] rd_addr;

  // Write side: accept whenever ready, sync realigns to address 0 and beats the wrap.
  always_comb begin
    accept       = bus.valid_i & ready_q & ~reset_i;
    wr_ptr       = bus.sync_i ? '0 : wr_addr_q;
    ready_d      = 1'b1;
    frame_done_d = 1'b0;
    wr_addr_d    = wr_addr_q;
    if (bus.sync_i) begin
      wr_addr_d = accept ? ADDR_W'(1) : '0;
    end else if (accept) begin
      if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
        wr_addr_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
    end
  end

  // Read side: look up the position the display will be at after this edge so data_o never lags.
  always_comb begin
    col_nxt = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
    row_nxt = row_q;
    if (col_q == COL_W'(COLS - 1)) begin
      row_nxt = (row_q == ROW_W'(DISP_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    end
    col_d   = bus.rd_ready_i ? col_nxt : col_q;
    row_d   = bus.rd_ready_i ? row_nxt : row_q;
    src_row = row_d >> SHIFT;
    src_col = col_d >> SHIFT;
    blank   = (int'(src_row) >= SRC_H);
    rd_addr = blank ? '0 : ADDR_W'(src_row) * ADDR_W'(SRC_W) + ADDR_W'(src_col);
    data_d  = blank ? '0 : mem[rd_addr];
  end

  // Pixel store; contents survive reset, read above sees the pre-write value on a collision.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem[wr_ptr] <= bus.data_i;
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      data_q       <= '0;
    end else begin
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      wr_addr_q    <= wr_addr_d;
      col_q        <= col_d;
      row_q        <= row_d;
      data_q       <= data_d;
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.data_o       = data_q;
endmodule

// File: tb/tb_thermal_frame_buffer.sv
// tb/tb_thermal_frame_buffer.sv - directed self-checking bench for thermal_frame_buffer
module tb_thermal_frame_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Instance 0 uses default geometry, instance 1 a tiny geometry with blank rows and row wrap.
  int    sw[2] = '{80, 4};
  int    sh[2] = '{60, 2};
  int    sc[2] = '{8, 2};
  int    dr[2] = '{400, 6};
  string nm[2] = '{"main", "small"};

  logic [15:0] mem_m [2][4800];
  bit          known [2][4800];
  int          m_col[2], m_row[2], m_wa[2];
  bit          m_rdy[2], m_fd[2];
  logic [15:0] exp_d[2];
  bit          exp_ok[2];

  always #20 clk = ~clk;

  thermal_frame_buffer_if #(.WIDTH(16)) bus ();
  thermal_frame_buffer_if #(.WIDTH(16)) sbus ();

  thermal_frame_buffer #(
    .WIDTH(16), .SRC_W(80), .SRC_H(60), .SCALE(8), .DISP_ROWS(400)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  thermal_frame_buffer #(
    .WIDTH(16), .SRC_W(4), .SRC_H(2), .SCALE(2), .DISP_ROWS(6)
  ) dut_s (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (sbus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] pix(input int k, input int c, input int r, output bit ok);
    int sr;
    int a;
    sr = r / sc[k];
    if (sr >= sh[k]) begin
      ok = 1'b1;
      return 16'h0000;
    end
    a  = sr * sw[k] + c / sc[k];
    ok = known[k][a];
    return mem_m[k][a];
  endfunction

  task automatic predict(input int k, input bit v, input bit s, input bit rr, input logic [15:0] d);
    bit acc;
    int a;
    if (rst) begin
      m_col[k] = 0; m_row[k] = 0; m_wa[k] = 0;
      m_fd[k] = 1'b0; m_rdy[k] = 1'b0;
      exp_d[k] = 16'h0000; exp_ok[k] = 1'b1;
      return;
    end
    if (rr) begin
      m_col[k]++;
      if (m_col[k] == sw[k] * sc[k]) begin
        m_col[k] = 0;
        m_row[k]++;
        if (m_row[k] == dr[k]) m_row[k] = 0;
      end
    end
    exp_d[k] = pix(k, m_col[k], m_row[k], exp_ok[k]);
    acc      = v && m_rdy[k];
    m_fd[k]  = 1'b0;
    if (acc) begin
      a = s ? 0 : m_wa[k];
      mem_m[k][a] = d;
      known[k][a] = 1'b1;
    end
    if (s) begin
      m_wa[k] = acc ? 1 : 0;
    end else if (acc) begin
      if (m_wa[k] == sw[k] * sh[k] - 1) begin
        m_wa[k] = 0;
        m_fd[k] = 1'b1;
      end else begin
        m_wa[k]++;
      end
    end
    m_rdy[k] = 1'b1;
  endtask

  task automatic tick();
    predict(0, bus.valid_i, bus.sync_i, bus.rd_ready_i, bus.data_i);
    predict(1, sbus.valid_i, sbus.sync_i, sbus.rd_ready_i, sbus.data_i);
    @(posedge clk);
    #1;
    check({nm[0], "_ready"}, {15'b0, bus.ready_o}, {15'b0, m_rdy[0]});
    check({nm[0], "_frame_done"}, {15'b0, bus.frame_done_o}, {15'b0, m_fd[0]});
    if (exp_ok[0]) check({nm[0], "_data"}, bus.data_o, exp_d[0]);
    check({nm[1], "_ready"}, {15'b0, sbus.ready_o}, {15'b0, m_rdy[1]});
    check({nm[1], "_frame_done"}, {15'b0, sbus.frame_done_o}, {15'b0, m_fd[1]});
    if (exp_ok[1]) check({nm[1], "_data"}, sbus.data_o, exp_d[1]);
  endtask

  initial begin
    int pulses;
    int last_idx;
    bus.valid_i = 1'b0;  bus.sync_i = 1'b0;  bus.rd_ready_i = 1'b0;  bus.data_i = '0;
    sbus.valid_i = 1'b0; sbus.sync_i = 1'b0; sbus.rd_ready_i = 1'b0; sbus.data_i = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Full source frame, data = index; exactly one frame_done pulse after pixel 4799.
    pulses = 0;
    last_idx = -1;
    bus.valid_i = 1'b1;
    for (int i = 0; i < 4800; i++) begin
      bus.data_i = 16'(i);
      tick();
      if (bus.frame_done_o) begin
        pulses++;
        last_idx = i;
      end
    end
    bus.valid_i = 1'b0;
    tick();
    check("fd_pulse_count", 16'(pulses), 16'd1);
    check("fd_pulse_index", 16'(last_idx), 16'd4799);

    // Continuous display scan across several replicated rows.
    bus.rd_ready_i = 1'b1;
    for (int i = 0; i < 640 * 16 + 300; i++) tick();

    // Random consume strobe: data holds on 0, advances one pixel per 1.
    for (int i = 0; i < 1500; i++) begin
      bus.rd_ready_i = 1'($urandom_range(0, 1));
      tick();
    end

    // Mid-frame realign: 100 pixels, then sync with a pixel, then one more pixel.
    bus.rd_ready_i = 1'b0;
    bus.valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.data_i = 16'h1000 + 16'(i);
      tick();
    end
    bus.sync_i = 1'b1;
    bus.data_i = 16'hBEEF;
    tick();
    bus.sync_i = 1'b0;
    bus.data_i = 16'hCAFE;
    tick();
    bus.valid_i = 1'b0;
    tick();

    // Reset mid-frame with a pending write and consume; memory must survive, write must not land.
    rst = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i = 16'hDEAD;
    bus.rd_ready_i = 1'b1;
    tick();
    check("reset_data_zero", bus.data_o, 16'h0000);
    rst = 1'b0;
    bus.valid_i = 1'b0;
    bus.rd_ready_i = 1'b0;
    tick();
    check("post_reset_mem0", bus.data_o, 16'hBEEF);

    // Write the address being displayed: old value first, new value on the next read.
    bus.valid_i = 1'b1;
    bus.data_i = 16'h5A5A;
    tick();
    check("collide_old", bus.data_o, 16'hBEEF);
    bus.valid_i = 1'b0;
    tick();
    check("collide_new", bus.data_o, 16'h5A5A);

    // Sync without a pixel rewinds the write pointer to 0.
    bus.sync_i = 1'b1;
    tick();
    bus.sync_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i = 16'h7777;
    tick();
    bus.valid_i = 1'b0;
    tick();
    check("sync_rewind", bus.data_o, 16'h7777);

    bus.rd_ready_i = 1'b1;
    for (int i = 0; i < 700; i++) tick();
    bus.rd_ready_i = 1'b0;

    // Small geometry: frame wrap pulse, blank rows and display row wrap.
    sbus.valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sbus.data_i = 16'h0100 + 16'(i);
      tick();
    end
    sbus.valid_i = 1'b0;
    sbus.rd_ready_i = 1'b1;
    for (int i = 0; i < 8 * 6 * 2 + 5; i++) tick();
    sbus.rd_ready_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
